// File: rtl/fft_bank_addr_gen_pkg.sv
// Shared definitions for the banked FFT sample-memory address generator.
// Holds the default geometry (128 points, 4 banks, 5-bit local addresses),
// the FSM state type and the bit-rotation helpers used for the LOAD
// permutation and the per-pass COMPUTE address twist.
package fft_pkg;

   localparam int DefAddrWidth = 7;
   localparam int DefNumBanks  = 4;
   localparam int DefPermBits  = 3;
   localparam int DefPermRot   = 1;
   localparam int DefNumStages = 3;
   localparam int DefStageGap  = 4;

   localparam int BankBits = $clog2(DefNumBanks);
   localparam int LocalW   = DefAddrWidth - BankBits;

   // Local (per-bank) address at the default geometry.
   typedef logic [LocalW-1:0] bank_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      GAP,
      DONE
   } fsm_e;

   // Rotate the low 'width' bits of val right by 'amt' (amt taken modulo width).
   // Bits above 'width' are cleared in the result.
   function automatic logic [31:0] rotr_bits(input logic [31:0] val,
                                             input int unsigned width,
                                             input int unsigned amt);
      logic [31:0] mask;
      logic [31:0] v;
      int unsigned a;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      v    = val & mask;
      a    = amt % width;
      return ((v >> a) | (v << (width - a))) & mask;
   endfunction

   // Rotate the low 'width' bits of val left by 'amt' (amt taken modulo width).
   function automatic logic [31:0] rotl_bits(input logic [31:0] val,
                                             input int unsigned width,
                                             input int unsigned amt);
      logic [31:0] mask;
      logic [31:0] v;
      int unsigned a;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      v    = val & mask;
      a    = amt % width;
      return ((v << a) | (v >> (width - a))) & mask;
   endfunction

endpackage

// File: rtl/fft_bank_addr_gen_if.sv
// Bus between the address generator and its surroundings: the input-stream
// handshake, the stall/start controls and all bank-side outputs.
//   slave  : the address generator (drives wen/ren/cs/addr/stage/status)
//   master : the controller/stream side (drives start, in_valid, stall)
interface fft_bank_addr_gen_if #(
   parameter int NumBanks = 4,
   parameter int LocalW   = 5,
   parameter int StageW   = 2
) ();

   logic                             start_i;
   logic                             in_valid_i;
   logic                             stall_i;
   logic                             in_ready_o;
   logic [NumBanks-1:0]              wen_o;
   logic [NumBanks-1:0]              ren_o;
   logic [$clog2(NumBanks)-1:0]      cs_o;
   logic [NumBanks-1:0][LocalW-1:0]  addr_o;
   logic [StageW-1:0]                stage_o;
   logic                             start_fft_o;
   logic                             busy_o;
   logic                             done_o;

   modport master (
      output start_i, in_valid_i, stall_i,
      input  in_ready_o, wen_o, ren_o, cs_o, addr_o, stage_o, start_fft_o, busy_o, done_o
   );

   modport slave (
      input  start_i, in_valid_i, stall_i,
      output in_ready_o, wen_o, ren_o, cs_o, addr_o, stage_o, start_fft_o, busy_o, done_o
   );

endinterface

// File: rtl/fft_bank_addr_gen_permute.sv
// addr_permute: purely combinational mapping from the shared sample counter
// to a bank index and a local (per-bank) address.
//   cnt        : sample counter (full AddrWidth during LOAD, low LocalW bits in COMPUTE)
//   load_mode  : 1 = LOAD mapping, 0 = COMPUTE mapping
//   stage      : current pass number (selects the COMPUTE rotation)
//   bank       : top BankBits of cnt
//   local_addr : LOAD  -> upper local bits unchanged, low PermBits rotated right by PermRot
//                COMPUTE -> whole local counter rotated left by stage (mod LocalW)
module addr_permute
   import fft_pkg::*;
#(
   parameter int AddrWidth = DefAddrWidth,
   parameter int NumBanks  = DefNumBanks,
   parameter int PermBits  = DefPermBits,
   parameter int PermRot   = DefPermRot,
   parameter int StageW    = 2
) (
   input  logic [AddrWidth-1:0]                   cnt,
   input  logic                                   load_mode,
   input  logic [StageW-1:0]                      stage,
   output logic [$clog2(NumBanks)-1:0]            bank,
   output logic [AddrWidth-$clog2(NumBanks)-1:0]  local_addr
);

   localparam int BankW = $clog2(NumBanks);
   localparam int LocW  = AddrWidth - BankW;
   localparam logic [LocW-1:0] LowMask = LocW'((32'd1 << PermBits) - 32'd1);

   logic [LocW-1:0] load_local;
   logic [LocW-1:0] comp_local;

   // The permuted field is merged back with a mask rather than a part-select
   // so that PermBits == LocW (whole local address permuted) needs no special case.
   always_comb begin
      bank       = cnt[AddrWidth-1 -: BankW];
      load_local = (cnt[LocW-1:0] & ~LowMask)
                 | LocW'(rotr_bits(32'(cnt[PermBits-1:0]), PermBits, PermRot));
      comp_local = LocW'(rotl_bits(32'(cnt[LocW-1:0]), LocW, 32'(stage)));
      local_addr = load_mode ? load_local : comp_local;
   end

endmodule

// File: rtl/fft_bank_addr_gen.sv
// fft_bank_addr_gen: address/enable sequencer for the banked FFT sample memory.
// LOAD writes one streamed sample per accepted beat into a permuted bank
// location; then NumStages COMPUTE passes read all banks in lock-step,
// separated by StageGap idle cycles for the butterfly pipeline to drain.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : start_i/in_valid_i/stall_i in; in_ready_o, wen_o, ren_o,
//                   cs_o, addr_o, stage_o, start_fft_o, busy_o, done_o out
// Every output is a register loaded from the state/counters of the previous
// cycle, except in_ready_o which is loaded from the next state so that it is
// high exactly in the cycles where a beat can be accepted.
module fft_bank_addr_gen
   import fft_pkg::*;
#(
   parameter int AddrWidth = DefAddrWidth,
   parameter int NumBanks  = DefNumBanks,
   parameter int PermBits  = DefPermBits,
   parameter int PermRot   = DefPermRot,
   parameter int NumStages = DefNumStages,
   parameter int StageGap  = DefStageGap
) (
   input logic               clk_i,
   input logic               rst_ni,
   fft_bank_addr_gen_if.slave bus
);

   localparam int BankW  = $clog2(NumBanks);
   localparam int LocW   = AddrWidth - BankW;
   localparam int StageW = $clog2(NumStages + 1);
   localparam int GapW   = (StageGap > 0) ? $clog2(StageGap + 1) : 1;

   fsm_e                 state_q, state_d;
   logic [AddrWidth-1:0] cnt_q, cnt_d;
   logic [StageW-1:0]    stage_q, stage_d;
   logic [GapW-1:0]      gap_q, gap_d;
   logic                 load_issue;
   logic                 comp_issue;
   logic [BankW-1:0]     bank;
   logic [LocW-1:0]      local_addr;

   addr_permute #(
      .AddrWidth (AddrWidth),
      .NumBanks  (NumBanks),
      .PermBits  (PermBits),
      .PermRot   (PermRot),
      .StageW    (StageW)
   ) u_permute (
      .cnt        (cnt_q),
      .load_mode  (state_q == LOAD),
      .stage      (stage_q),
      .bank       (bank),
      .local_addr (local_addr)
   );

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stage_q <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         gap_q   <= gap_d;
      end
   end

   // Next-state logic. One counter serves both LOAD (full width) and COMPUTE
   // (low LocW bits); it is cleared explicitly at the end of every pass.
   // load_issue/comp_issue mark the cycles that produce a write or a read.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stage_d    = stage_q;
      gap_d      = gap_q;
      load_issue = 1'b0;
      comp_issue = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = LOAD;
               cnt_d   = '0;
               stage_d = '0;
            end
         end
         LOAD: begin
            if (bus.in_valid_i) begin
               load_issue = 1'b1;
               cnt_d      = cnt_q + AddrWidth'(1);
               if (&cnt_q) begin
                  state_d = COMPUTE;
               end
            end
         end
         COMPUTE: begin
            if (!bus.stall_i) begin
               comp_issue = 1'b1;
               if (&cnt_q[LocW-1:0]) begin
                  cnt_d = '0;
                  if (stage_q == StageW'(NumStages - 1)) begin
                     state_d = DONE;
                  end else if (StageGap == 0) begin
                     stage_d = stage_q + StageW'(1);
                  end else begin
                     state_d = GAP;
                     gap_d   = GapW'(StageGap);
                  end
               end else begin
                  cnt_d = cnt_q + AddrWidth'(1);
               end
            end
         end
         GAP: begin
            if (!bus.stall_i) begin
               if (gap_q == GapW'(1)) begin
                  state_d = COMPUTE;
                  stage_d = stage_q + StageW'(1);
               end else begin
                  gap_d = gap_q - GapW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output registers. A write updates only the addressed lane and cs_o; a
   // read updates every lane; otherwise addresses and cs_o hold their value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.in_ready_o  <= 1'b0;
         bus.wen_o       <= '0;
         bus.ren_o       <= '0;
         bus.cs_o        <= '0;
         bus.addr_o      <= '0;
         bus.stage_o     <= '0;
         bus.start_fft_o <= 1'b0;
         bus.busy_o      <= 1'b0;
         bus.done_o      <= 1'b0;
      end else begin
         bus.in_ready_o  <= (state_d == LOAD);
         bus.busy_o      <= (state_q != IDLE);
         bus.wen_o       <= load_issue ? (NumBanks'(1) << bank) : '0;
         bus.ren_o       <= comp_issue ? '1 : '0;
         bus.start_fft_o <= comp_issue && (cnt_q[LocW-1:0] == '0);
         bus.stage_o     <= (state_q == COMPUTE || state_q == GAP) ? stage_q : '0;
         bus.done_o      <= (state_q == DONE);
         if (load_issue) begin
            bus.cs_o         <= bank;
            bus.addr_o[bank] <= local_addr;
         end else if (comp_issue) begin
            for (int i = 0; i < NumBanks; i++) begin
               bus.addr_o[i] <= local_addr;
            end
         end
      end
   end

endmodule
